// File: rtl/updi_transaction_if.sv
// updi_transaction_if: host-side and uart_fifo-side signal bundle for updi_transaction
// Signals: start, tx_len, rx_len; tx_byte/tx_byte_valid/tx_byte_ready; rx_byte/rx_byte_valid;
//   busy, done, err_code; uf_tx_data, uf_tx_fifo_wr_en, uf_tx_fifo_full, uf_rx_data,
//   uf_rx_fifo_rd_en, uf_rx_fifo_empty, uf_rx_error, uf_uart_busy.
// Modports: slave = the transaction engine, master = host plus uart_fifo environment.
interface updi_transaction_if #(
  parameter int MAX_LEN = 16
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  logic             start;
  logic [LEN_W-1:0] tx_len;
  logic [LEN_W-1:0] rx_len;
  logic [7:0]       tx_byte;
  logic             tx_byte_valid;
  logic             tx_byte_ready;
  logic [7:0]       rx_byte;
  logic             rx_byte_valid;
  logic             busy;
  logic             done;
  logic [1:0]       err_code;
  logic [7:0]       uf_tx_data;
  logic             uf_tx_fifo_wr_en;
  logic             uf_tx_fifo_full;
  logic [7:0]       uf_rx_data;
  logic             uf_rx_fifo_rd_en;
  logic             uf_rx_fifo_empty;
  logic             uf_rx_error;
  logic             uf_uart_busy;
  modport slave (
    input  start, tx_len, rx_len, tx_byte, tx_byte_valid,
           uf_tx_fifo_full, uf_rx_data, uf_rx_fifo_empty, uf_rx_error, uf_uart_busy,
    output tx_byte_ready, rx_byte, rx_byte_valid, busy, done, err_code,
           uf_tx_data, uf_tx_fifo_wr_en, uf_rx_fifo_rd_en
  );
  modport master (
    output start, tx_len, rx_len, tx_byte, tx_byte_valid,
           uf_tx_fifo_full, uf_rx_data, uf_rx_fifo_empty, uf_rx_error, uf_uart_busy,
    input  tx_byte_ready, rx_byte, rx_byte_valid, busy, done, err_code,
           uf_tx_data, uf_tx_fifo_wr_en, uf_rx_fifo_rd_en
  );
endinterface

// File: rtl/updi_transaction.sv
// updi_transaction: UPDI byte transaction sequencer with echo checking over a uart_fifo
// Ports: clk, rst (synchronous, active high); bus (slave modport of updi_transaction_if)
//   carrying the host transaction/byte streams and the uart_fifo tx/rx FIFO controls.
module updi_transaction #(
  parameter int MAX_LEN    = 16,
  parameter int ECHO_DEPTH = 4,
  parameter int TIMEOUT    = 50000
) (
  input logic               clk,
  input logic               rst,
  updi_transaction_if.slave bus
);
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int PW    = $clog2(ECHO_DEPTH);
  localparam int OW    = $clog2(ECHO_DEPTH + 1);
  typedef enum logic [2:0] {IDLE, SEND, ECHO, RECV, FLUSH, DONE} state_t;
  state_t           state_q, state_d;
  logic [1:0]       err_q, err_d;
  logic [LEN_W-1:0] tx_len_q, rx_len_q, sent_q, rcvd_q, tx_cl, rx_cl;
  logic [PW-1:0]    wp_q, rp_q;
  logic [OW-1:0]    outst_q;
  logic [15:0]      tmo_q;
  logic [7:0]       echo_q [ECHO_DEPTH];
  logic             push, echo_pop, echo_ok, recv_pop, any_pop, tmo_run, tmo_hit, line_err;
  assign tx_cl = bus.tx_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : bus.tx_len;
  assign rx_cl = bus.rx_len > LEN_W'(MAX_LEN) ? LEN_W'(MAX_LEN) : bus.rx_len;
  // every FIFO-facing strobe is gated by rst so outputs read zero during reset
  assign bus.tx_byte_ready = !rst && state_q == SEND && sent_q < tx_len_q &&
                             !bus.uf_tx_fifo_full && outst_q < OW'(ECHO_DEPTH);
  assign push     = bus.tx_byte_ready && bus.tx_byte_valid;
  assign echo_pop = !rst && (state_q == SEND || state_q == ECHO) &&
                    !bus.uf_rx_fifo_empty && outst_q != '0;
  assign echo_ok  = echo_pop && bus.uf_rx_data == echo_q[rp_q];
  assign recv_pop = !rst && state_q == RECV && !bus.uf_rx_fifo_empty;
  assign any_pop  = echo_pop || recv_pop || (!rst && state_q == FLUSH && !bus.uf_rx_fifo_empty);
  assign tmo_run  = state_q == ECHO || state_q == RECV || (state_q == SEND && outst_q != '0);
  // a byte arriving on the expiry cycle wins over the timeout
  assign tmo_hit  = tmo_run && !any_pop && tmo_q == 16'(TIMEOUT - 1);
  assign line_err = bus.uf_rx_error && state_q inside {SEND, ECHO, RECV};
  assign bus.uf_tx_data       = push ? bus.tx_byte : 8'h00;
  assign bus.uf_tx_fifo_wr_en = push;
  assign bus.uf_rx_fifo_rd_en = any_pop;
  assign bus.rx_byte_valid    = recv_pop;
  assign bus.rx_byte          = recv_pop ? bus.uf_rx_data : 8'h00;
  assign bus.busy             = !rst && state_q != IDLE;
  assign bus.done             = !rst && state_q == DONE;
  assign bus.err_code         = rst ? 2'd0 : err_q;
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (state_q == IDLE) begin
      if (bus.start) begin
        state_d = tx_cl != '0 ? SEND : rx_cl != '0 ? RECV : DONE;
        err_d   = 2'd0;
      end
    end else if (line_err) begin
      state_d = FLUSH;
      err_d   = 2'd3;
    end else if (echo_pop && !echo_ok) begin
      state_d = FLUSH;
      err_d   = 2'd1;
    end else if (tmo_hit) begin
      state_d = FLUSH;
      err_d   = 2'd2;
    end else if (state_q == SEND) begin
      state_d = sent_q == tx_len_q ? ECHO : SEND;
    end else if (state_q == ECHO) begin
      state_d = outst_q != '0 ? ECHO : rx_len_q != '0 ? RECV : DONE;
    end else if (state_q == RECV) begin
      state_d = recv_pop && rcvd_q == rx_len_q - 1'b1 ? DONE : RECV;
    end else if (state_q == FLUSH) begin
      state_d = bus.uf_rx_fifo_empty && !bus.uf_uart_busy ? DONE : FLUSH;
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      err_q    <= '0;
      tx_len_q <= '0;
      rx_len_q <= '0;
      sent_q   <= '0;
      rcvd_q   <= '0;
      wp_q     <= '0;
      rp_q     <= '0;
      outst_q  <= '0;
      tmo_q    <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      tmo_q   <= (state_d != state_q || any_pop) ? '0 : tmo_q + 16'(tmo_run);
      if (state_q == IDLE && bus.start) begin
        tx_len_q <= tx_cl;
        rx_len_q <= rx_cl;
        sent_q   <= '0;
        rcvd_q   <= '0;
        wp_q     <= '0;
        rp_q     <= '0;
        outst_q  <= '0;
      end else begin
        if (push) echo_q[wp_q] <= bus.tx_byte;
        wp_q    <= wp_q + PW'(push);
        sent_q  <= sent_q + LEN_W'(push);
        rp_q    <= rp_q + PW'(echo_pop);
        outst_q <= outst_q + OW'(push) - OW'(echo_ok);
        rcvd_q  <= rcvd_q + LEN_W'(recv_pop);
      end
    end
  end
endmodule

// File: tb/tb_updi_transaction.sv
// tb_updi_transaction: scoreboard bench for updi_transaction with a uart_fifo loopback model
module tb_updi_transaction;
  localparam int TMO = 100;
  localparam int LW  = $clog2(17);
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  updi_transaction_if #(.MAX_LEN(16)) bus ();
  updi_transaction #(.MAX_LEN(16), .ECHO_DEPTH(4), .TIMEOUT(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));
  int compared = 0, mismatched = 0;
  int cyc = 0, wr_cnt = 0, rd_cnt = 0, rx_cnt = 0, done_cnt = 0, echo_delay = 2;
  bit echo_hold = 1'b0, corrupt = 1'b0;
  logic last_ready, last_busy;
  logic [1:0] last_err, done_err;
  logic [23:0] last_outs;
  logic [7:0] srcq[$], exp_tx[$], exp_rx[$], rxq[$], echo_b[$];
  int echo_t[$];

  task automatic drive();
    bus.uf_rx_fifo_empty = rxq.size() == 0;
    bus.uf_rx_data       = rxq.size() != 0 ? rxq[0] : 8'h00;
    bus.tx_byte_valid    = srcq.size() != 0;
    bus.tx_byte          = srcq.size() != 0 ? srcq[0] : 8'h00;
  endtask

  // one clock: observe at negedge, then advance the FIFO model after the edge
  task automatic cycle();
    bit pop, xfer;
    logic [7:0] w;
    drive();
    @(negedge clk);
    pop  = bus.uf_rx_fifo_rd_en;
    xfer = bus.tx_byte_valid && bus.tx_byte_ready;
    last_ready = bus.tx_byte_ready;
    last_busy  = bus.busy;
    last_err   = bus.err_code;
    last_outs  = {bus.done, bus.rx_byte_valid, bus.tx_byte_ready, bus.uf_tx_fifo_wr_en,
                  bus.uf_rx_fifo_rd_en, bus.busy, bus.err_code, bus.rx_byte, bus.uf_tx_data};
    if (bus.uf_tx_fifo_wr_en) begin
      wr_cnt++;
      w = 8'hxx;
      if (exp_tx.size() != 0) w = exp_tx.pop_front();
      compared++;
      if (bus.uf_tx_data !== w) begin
        mismatched++;
        $display("FAIL tx_data: got %h, want %h", bus.uf_tx_data, w);
      end
      echo_b.push_back(bus.uf_tx_data ^ {7'd0, corrupt});
      echo_t.push_back(cyc + echo_delay);
      corrupt = 1'b0;
    end
    if (bus.rx_byte_valid) begin
      rx_cnt++;
      w = 8'hxx;
      if (exp_rx.size() != 0) w = exp_rx.pop_front();
      compared++;
      if (bus.rx_byte !== w) begin
        mismatched++;
        $display("FAIL rx_byte: got %h, want %h", bus.rx_byte, w);
      end
    end
    if (pop) rd_cnt++;
    if (bus.done) begin
      done_cnt++;
      done_err = bus.err_code;
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pop && rxq.size() != 0) rxq.delete(0);
    if (xfer && srcq.size() != 0) srcq.delete(0);
    while (!echo_hold && echo_t.size() != 0 && echo_t[0] <= cyc) begin
      rxq.push_back(echo_b.pop_front());
      echo_t.delete(0);
    end
    drive();
  endtask

  task automatic wait_done(input int limit, output int n);
    int d0;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < limit) begin
      cycle();
      n++;
    end
    if (done_cnt == d0) begin
      compared++;
      mismatched++;
      $display("FAIL done_wait: no done within %0d cycles", limit);
    end
  endtask

  task automatic kick(input logic [LW-1:0] t, input logic [LW-1:0] r);
    bus.tx_len = t;
    bus.rx_len = r;
    bus.start  = 1'b1;
    cycle();
    bus.start  = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.tx_len = '0;
    bus.rx_len = '0;
    bus.uf_tx_fifo_full = 1'b0;
    bus.uf_rx_error = 1'b0;
    bus.uf_uart_busy = 1'b0;
    rst = 1'b1;
    repeat (3) cycle();
    compared++;
    if (last_outs !== 24'h0) begin mismatched++; $display("FAIL reset_outputs: got %h, want 0", last_outs); end
    rst = 1'b0;
    cycle();
    compared++;
    if (last_busy !== 1'b0) begin mismatched++; $display("FAIL idle_busy: got %b, want 0", last_busy); end
  endtask

  task automatic test_basic();
    int w0, r0, n;
    w0 = wr_cnt;
    r0 = rx_cnt;
    echo_delay = 2;
    srcq.push_back(8'h55); exp_tx.push_back(8'h55);
    srcq.push_back(8'h80); exp_tx.push_back(8'h80);
    kick(5'd2, 5'd1);
    for (int i = 0; i < 50 && wr_cnt < w0 + 2; i++) cycle();
    echo_b.push_back(8'h30); echo_t.push_back(cyc + 1); exp_rx.push_back(8'h30);
    wait_done(200, n);
    compared++;
    if (wr_cnt - w0 !== 2) begin mismatched++; $display("FAIL basic_wr_count: got %0d, want 2", wr_cnt - w0); end
    compared++;
    if (rx_cnt - r0 !== 1) begin mismatched++; $display("FAIL basic_rx_count: got %0d, want 1", rx_cnt - r0); end
    compared++;
    if (done_err !== 2'd0) begin mismatched++; $display("FAIL basic_err: got %0d, want 0", done_err); end
  endtask

  task automatic test_echo_mismatch();
    int w0, r0, d0, n;
    w0 = wr_cnt;
    r0 = rd_cnt;
    d0 = done_cnt;
    bus.uf_uart_busy = 1'b1;
    corrupt = 1'b1;
    srcq.push_back(8'h55); exp_tx.push_back(8'h55);
    kick(5'd1, 5'd1);
    for (int i = 0; i < 50 && wr_cnt < w0 + 1; i++) cycle();
    echo_b.push_back(8'h11); echo_t.push_back(cyc + 1);
    echo_b.push_back(8'h22); echo_t.push_back(cyc + 1);
    repeat (15) cycle();
    compared++;
    if (done_cnt !== d0) begin mismatched++; $display("FAIL flush_done_early: got %0d, want %0d", done_cnt, d0); end
    compared++;
    if (rxq.size() + echo_b.size() !== 0) begin mismatched++; $display("FAIL flush_drain: got %0d left, want 0", rxq.size() + echo_b.size()); end
    compared++;
    if (rd_cnt - r0 !== 3) begin mismatched++; $display("FAIL flush_pops: got %0d, want 3", rd_cnt - r0); end
    compared++;
    if (last_busy !== 1'b1) begin mismatched++; $display("FAIL flush_busy: got %b, want 1", last_busy); end
    bus.uf_uart_busy = 1'b0;
    wait_done(10, n);
    compared++;
    if (n !== 2) begin mismatched++; $display("FAIL flush_exit_latency: got %0d, want 2", n); end
    compared++;
    if (done_err !== 2'd1) begin mismatched++; $display("FAIL mismatch_err: got %0d, want 1", done_err); end
  endtask

  task automatic test_timeout();
    int n;
    kick(5'd0, 5'd3);
    wait_done(300, n);
    // TIMEOUT cycles in RECV, one cycle in FLUSH, then DONE is visible
    compared++;
    if (n !== TMO + 2) begin mismatched++; $display("FAIL timeout_latency: got %0d, want %0d", n, TMO + 2); end
    compared++;
    if (done_err !== 2'd2) begin mismatched++; $display("FAIL timeout_err: got %0d, want 2", done_err); end
  endtask

  task automatic test_backpressure();
    int w0, n;
    w0 = wr_cnt;
    for (int i = 0; i < 8; i++) begin
      srcq.push_back(8'(8'h10 + i));
      exp_tx.push_back(8'(8'h10 + i));
    end
    echo_hold = 1'b1;
    echo_delay = 3;
    kick(5'd8, 5'd0);
    repeat (20) cycle();
    compared++;
    if (wr_cnt - w0 !== 4) begin mismatched++; $display("FAIL bp_wr_held: got %0d, want 4", wr_cnt - w0); end
    compared++;
    if (last_ready !== 1'b0) begin mismatched++; $display("FAIL bp_ready: got %b, want 0", last_ready); end
    echo_hold = 1'b0;
    wait_done(300, n);
    compared++;
    if (wr_cnt - w0 !== 8) begin mismatched++; $display("FAIL bp_wr_total: got %0d, want 8", wr_cnt - w0); end
    compared++;
    if (done_err !== 2'd0) begin mismatched++; $display("FAIL bp_err: got %0d, want 0", done_err); end
  endtask

  task automatic test_line_error();
    int d0, r0, n;
    d0 = done_cnt;
    r0 = rx_cnt;
    rxq.push_back(8'hA5); exp_rx.push_back(8'hA5);
    kick(5'd0, 5'd2);
    bus.start = 1'b1;
    bus.rx_len = 5'd1;
    for (int i = 0; i < 50 && rx_cnt == r0; i++) cycle();
    bus.uf_rx_error = 1'b1;
    cycle();
    bus.uf_rx_error = 1'b0;
    wait_done(20, n);
    bus.start = 1'b0;
    repeat (3) cycle();
    compared++;
    if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL line_done_count: got %0d, want 1", done_cnt - d0); end
    compared++;
    if (done_err !== 2'd3) begin mismatched++; $display("FAIL line_err: got %0d, want 3", done_err); end
    compared++;
    if (rx_cnt - r0 !== 1) begin mismatched++; $display("FAIL line_rx_count: got %0d, want 1", rx_cnt - r0); end
    compared++;
    if (last_err !== 2'd3) begin mismatched++; $display("FAIL err_hold: got %0d, want 3", last_err); end
    compared++;
    if (last_busy !== 1'b0) begin mismatched++; $display("FAIL line_idle: got %b, want 0", last_busy); end
  endtask

  task automatic test_zero_len();
    int d0, n;
    d0 = done_cnt;
    kick(5'd0, 5'd0);
    wait_done(5, n);
    compared++;
    if (n !== 1) begin mismatched++; $display("FAIL zero_latency: got %0d, want 1", n); end
    compared++;
    if (done_err !== 2'd0) begin mismatched++; $display("FAIL zero_err: got %0d, want 0", done_err); end
    cycle();
    compared++;
    if (done_cnt - d0 !== 1) begin mismatched++; $display("FAIL zero_pulse: got %0d, want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_mid();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < 4; i++) begin
      srcq.push_back(8'(8'hC0 + i));
      exp_tx.push_back(8'(8'hC0 + i));
    end
    echo_hold = 1'b1;
    kick(5'd4, 5'd0);
    repeat (2) cycle();
    rst = 1'b1;
    cycle();
    cycle();
    compared++;
    if (last_outs !== 24'h0) begin mismatched++; $display("FAIL mid_reset_outputs: got %h, want 0", last_outs); end
    srcq.delete();
    exp_tx.delete();
    echo_b.delete();
    echo_t.delete();
    rxq.delete();
    echo_hold = 1'b0;
    rst = 1'b0;
    repeat (10) cycle();
    compared++;
    if (done_cnt !== d0) begin mismatched++; $display("FAIL mid_reset_done: got %0d, want %0d", done_cnt, d0); end
    compared++;
    if (last_busy !== 1'b0) begin mismatched++; $display("FAIL mid_reset_busy: got %b, want 0", last_busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_echo_mismatch();
    test_timeout();
    test_backpressure();
    test_line_error();
    test_zero_len();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/updi_transaction.md
UPDI_TRANSACTION -- requirements
Module: updi_transaction

Interface
REQ-001 The block SHALL have parameter MAX_LEN, default 16: maximum tx and rx byte count per transaction; LEN_W = $clog2(MAX_LEN+1).
REQ-002 The block SHALL have parameter ECHO_DEPTH, default 4: maximum bytes pushed whose echo is not yet consumed; power of 2.
REQ-003 The block SHALL have parameter TIMEOUT, default 50000: idle clocks allowed while waiting for any rx byte.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: begins a transaction; sampled in IDLE only.
REQ-007 The block SHALL have ports tx_len and rx_len, input, LEN_W each: byte counts, sampled on start; values above MAX_LEN are clamped to MAX_LEN.
REQ-008 The block SHALL have ports tx_byte (input, 8), tx_byte_valid (input, 1) and tx_byte_ready (output, 1): outgoing byte stream; a byte transfers when valid and ready are both high.
REQ-009 The block SHALL have ports rx_byte (output, 8) and rx_byte_valid (output, 1): response bytes, one-cycle pulse per byte, no backpressure.
REQ-010 The block SHALL have outputs busy (1), done (1-cycle pulse) and err_code (2; 0 none, 1 echo mismatch, 2 timeout, 3 line error).
REQ-011 The block SHALL have uart_fifo-side ports: uf_tx_data (output, 8), uf_tx_fifo_wr_en (output, 1), uf_tx_fifo_full (input, 1), uf_rx_data (input, 8), uf_rx_fifo_rd_en (output, 1), uf_rx_fifo_empty (input, 1), uf_rx_error (input, 1), uf_uart_busy (input, 1).

Function
REQ-012 uf_rx_data SHALL be treated as the rx FIFO head, valid whenever uf_rx_fifo_empty=0; a one-cycle uf_rx_fifo_rd_en pops it, with at most one pop per cycle.
REQ-013 The FSM states SHALL be IDLE, SEND, ECHO, RECV, FLUSH and DONE.
REQ-014 IDLE + start SHALL latch the lengths, clear the counters, and go to SEND if tx_len>0, else RECV if rx_len>0, else DONE.
REQ-015 tx_byte_ready SHALL be 1 only in SEND, while sent<tx_len, uf_tx_fifo_full=0, and outstanding<ECHO_DEPTH; it is combinational from state and counters, not from tx_byte_valid.
REQ-016 On each transfer the block SHALL drive uf_tx_data=tx_byte and pulse uf_tx_fifo_wr_en in that same cycle, write the byte into the circular echo buffer (depth ECHO_DEPTH), and increment sent and outstanding.
REQ-017 In SEND/ECHO, when the rx FIFO is not empty and outstanding>0, the block SHALL pop one byte and compare it with the echo-buffer head; a match decrements outstanding, a mismatch sets err_code=1 and goes to FLUSH.
REQ-018 A push and an echo pop in the same cycle SHALL leave outstanding unchanged; both pointers wrap modulo ECHO_DEPTH.
REQ-019 SEND SHALL go to ECHO when sent==tx_len; ECHO SHALL go to RECV (rx_len>0) or DONE once outstanding==0.
REQ-020 RECV SHALL pop one byte per available rx byte, present it on rx_byte with rx_byte_valid=1 in the pop cycle, and go to DONE after rx_len bytes.
REQ-021 A 16-bit-wide timeout counter SHALL clear on every rx pop and on state entry, and SHALL increment in ECHO/RECV, and in SEND while outstanding>0; reaching TIMEOUT SHALL set err_code=2 and go to FLUSH.
REQ-022 uf_rx_error=1 in any state except IDLE/DONE SHALL set err_code=3 and go to FLUSH; in FLUSH it is ignored and it never overrides an error code already set.
REQ-023 FLUSH SHALL pop the rx FIFO while it is not empty, and go to DONE only when uf_rx_fifo_empty=1 and uf_uart_busy=0 in the same cycle; tx_byte_ready=0 in FLUSH.
REQ-024 DONE SHALL pulse done for one cycle with err_code held valid, then return to IDLE; err_code holds until the next start.
REQ-025 busy SHALL be 1 in every state except IDLE; start outside IDLE SHALL be ignored.

Reset
REQ-026 While rst=1, the state SHALL be IDLE, and all counters and echo pointers SHALL be 0.
REQ-027 While rst=1, done, rx_byte_valid, tx_byte_ready, uf_tx_fifo_wr_en, uf_rx_fifo_rd_en, busy, err_code, rx_byte and uf_tx_data SHALL all be 0.
REQ-028 Reset mid-transaction SHALL abort immediately with no done pulse.

Verification
REQ-029 The bench SHALL cover: tx_len=2 (0x55,0x80), rx_len=1; model echoes 0x55,0x80, then responds 0x30 -> two wr_en pulses, rx_byte=0x30 pulsed once, done with err_code=0.
REQ-030 The bench SHALL cover: tx_len=1 (0x55), echo returned as 0x54 -> err_code=1; FLUSH drains the rx FIFO; done is asserted once the FIFO is empty and uart_busy=0.
REQ-031 The bench SHALL cover: tx_len=0, rx_len=3, no rx bytes, TIMEOUT=100 -> done with err_code=2 exactly 100 cycles after entering RECV, counted in the RECV timeout-counter increments.
REQ-032 The bench SHALL cover: tx_len=8, ECHO_DEPTH=4, echoes delayed -> tx_byte_ready low while outstanding=4; no wrap-around miscompare; err_code=0.
REQ-033 The bench SHALL cover: uf_rx_error pulsed during RECV -> err_code=3; start held high during the transaction is ignored.
REQ-034 The bench SHALL cover: tx_len=rx_len=0 -> done in the second cycle after start; rst asserted mid-SEND -> all outputs 0 in the next cycle and no done.
